w0rm_bus_arbiter: RTL and testbench

W0RM_BUS_ARBITER -- requirements
Module: w0rm_bus_arbiter

---
 rtl/w0rm_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_w0rm_bus_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w0rm_bus_arbiter.sv
// w0rm_bus_arbiter: shares one bus between an instruction-fetch port and a
// data port. One transaction is outstanding at a time. Data requests are
// preferred, but an instruction fetch is forced through after
// MAX_DATA_BURST consecutive data grants made while it was waiting.
// A bus that never answers is cut off after TIMEOUT_CYCLES and the owner
// receives an error response.
module w0rm_bus_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int INST_WIDTH     = 16,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    input  logic                  inst_req_i,
    output logic [INST_WIDTH-1:0] inst_data_o,
    output logic                  inst_valid_o,
    output logic                  inst_err_o,

    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic                  mem_req_i,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_valid_o,
    output logic                  mem_err_o,

    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    output logic                  bus_read_o,
    output logic                  bus_write_o,
    output logic                  bus_valid_o,
    input  logic [DATA_WIDTH-1:0] bus_data_i,
    input  logic                  bus_valid_i
);

    localparam int STREAK_W = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX   = STREAK_W'(MAX_DATA_BURST);
    localparam logic [15:0]         TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } state_t;

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic [15:0]         tcnt;
    logic                owner_write;

    logic                mem_is_write;
    logic                grant_d;
    logic                grant_i;
    logic                bus_timeout;
    logic                busy;

    // Request decode and arbitration decision; only acted upon in IDLE
    always_comb begin
        grant_d      = 1'b0;
        grant_i      = 1'b0;
        // Both or neither of read/write set means a read
        mem_is_write = mem_write_i && !mem_read_i;
        busy         = (state == BUSY_I) || (state == BUSY_D);
        bus_timeout  = (tcnt == TIMEOUT_LAST);
        if (mem_req_i && !(inst_req_i && (streak == STREAK_MAX))) begin
            grant_d = 1'b1;
        end else if (inst_req_i) begin
            grant_i = 1'b1;
        end
    end

    // Streak counter: consecutive data grants taken while a fetch was waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                if (!inst_req_i) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end else if (grant_i) begin
                streak <= '0;
            end
        end
    end

    // Timeout counter: cleared on grant, counts every cycle spent waiting on the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
        end else if (state == IDLE) begin
            if (grant_d || grant_i) begin
                tcnt <= '0;
            end
        end else if (busy) begin
            tcnt <= tcnt + 16'd1;
        end
    end

    // Transaction FSM with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner_write  <= 1'b0;
            bus_addr_o   <= '0;
            bus_data_o   <= '0;
            bus_read_o   <= 1'b0;
            bus_write_o  <= 1'b0;
            bus_valid_o  <= 1'b0;
            inst_data_o  <= '0;
            inst_valid_o <= 1'b0;
            inst_err_o   <= 1'b0;
            mem_data_o   <= '0;
            mem_valid_o  <= 1'b0;
            mem_err_o    <= 1'b0;
        end else begin
            // Response strobes are single-cycle; data outputs hold between strobes
            inst_valid_o <= 1'b0;
            inst_err_o   <= 1'b0;
            mem_valid_o  <= 1'b0;
            mem_err_o    <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state       <= BUSY_D;
                        owner_write <= mem_is_write;
                        bus_addr_o  <= mem_addr_i;
                        bus_data_o  <= mem_data_i;
                        bus_read_o  <= !mem_is_write;
                        bus_write_o <= mem_is_write;
                        bus_valid_o <= 1'b1;
                    end else if (grant_i) begin
                        state       <= BUSY_I;
                        owner_write <= 1'b0;
                        bus_addr_o  <= inst_addr_i;
                        bus_data_o  <= '0;
                        bus_read_o  <= 1'b1;
                        bus_write_o <= 1'b0;
                        bus_valid_o <= 1'b1;
                    end
                end

                BUSY_I: begin
                    if (bus_valid_i || bus_timeout) begin
                        state        <= RESP;
                        bus_read_o   <= 1'b0;
                        bus_write_o  <= 1'b0;
                        bus_valid_o  <= 1'b0;
                        inst_valid_o <= 1'b1;
                        inst_err_o   <= !bus_valid_i;
                        inst_data_o  <= bus_valid_i ? bus_data_i[INST_WIDTH-1:0] : '0;
                    end
                end

                BUSY_D: begin
                    if (bus_valid_i || bus_timeout) begin
                        state       <= RESP;
                        bus_read_o  <= 1'b0;
                        bus_write_o <= 1'b0;
                        bus_valid_o <= 1'b0;
                        mem_valid_o <= 1'b1;
                        mem_err_o   <= !bus_valid_i;
                        // Write acks and timeouts return zero data
                        mem_data_o  <= (bus_valid_i && !owner_write) ? bus_data_i : '0;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_w0rm_bus_arbiter.sv
// Self-checking bench for w0rm_bus_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_w0rm_bus_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int IW   = 16;
    localparam int MAXB = 4;
    localparam int TO   = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] inst_addr_i;
    logic          inst_req_i;
    logic [IW-1:0] inst_data_o;
    logic          inst_valid_o;
    logic          inst_err_o;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_data_i;
    logic          mem_read_i;
    logic          mem_write_i;
    logic          mem_req_i;
    logic [DW-1:0] mem_data_o;
    logic          mem_valid_o;
    logic          mem_err_o;
    logic [AW-1:0] bus_addr_o;
    logic [DW-1:0] bus_data_o;
    logic          bus_read_o;
    logic          bus_write_o;
    logic          bus_valid_o;
    logic [DW-1:0] bus_data_i;
    logic          bus_valid_i;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int            streak_m = 0;
    logic [IW-1:0] held_inst = '0;
    logic [DW-1:0] held_mem  = '0;

    w0rm_bus_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .INST_WIDTH    (IW),
        .MAX_DATA_BURST(MAXB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inst_addr_i (inst_addr_i),
        .inst_req_i  (inst_req_i),
        .inst_data_o (inst_data_o),
        .inst_valid_o(inst_valid_o),
        .inst_err_o  (inst_err_o),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_read_i  (mem_read_i),
        .mem_write_i (mem_write_i),
        .mem_req_i   (mem_req_i),
        .mem_data_o  (mem_data_o),
        .mem_valid_o (mem_valid_o),
        .mem_err_o   (mem_err_o),
        .bus_addr_o  (bus_addr_o),
        .bus_data_o  (bus_data_o),
        .bus_read_o  (bus_read_o),
        .bus_write_o (bus_write_o),
        .bus_valid_o (bus_valid_o),
        .bus_data_i  (bus_data_i),
        .bus_valid_i (bus_valid_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Advance one cycle; sample point is 1ns after the rising edge.
    // A bus_valid_i pulse lasts exactly one sampled edge.
    task automatic step();
        @(posedge clk);
        #1;
        bus_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        inst_req_i  = 1'b0;
        inst_addr_i = '0;
        mem_req_i   = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        mem_addr_i  = '0;
        mem_data_i  = '0;
        bus_valid_i = 1'b0;
        bus_data_i  = '0;
        step();
        step();
        reset     = 1'b0;
        streak_m  = 0;
        held_inst = '0;
        held_mem  = '0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({inst_data_o, inst_valid_o, inst_err_o, mem_data_o, mem_valid_o, mem_err_o,
             bus_addr_o, bus_data_o, bus_read_o, bus_write_o, bus_valid_o} !== '0) begin
            failures++;
            $display("FAIL %s: outputs not all zero (bus_valid=%b inst_valid=%b mem_valid=%b bus_addr=%h inst_data=%h mem_data=%h)",
                     name, bus_valid_o, inst_valid_o, mem_valid_o, bus_addr_o, inst_data_o, mem_data_o);
        end
    endtask

    // Between transactions: no bus activity, no strobes, response data held
    task automatic check_quiet(input string name);
        checks++;
        if ({bus_valid_o, inst_valid_o, inst_err_o, mem_valid_o, mem_err_o} !== 5'b0 ||
            inst_data_o !== held_inst || mem_data_o !== held_mem) begin
            failures++;
            $display("FAIL %s: got bv=%b iv=%b ie=%b mv=%b me=%b idata=%h mdata=%h, expected quiet with idata=%h mdata=%h",
                     name, bus_valid_o, inst_valid_o, inst_err_o, mem_valid_o, mem_err_o,
                     inst_data_o, mem_data_o, held_inst, held_mem);
        end
    endtask

    task automatic check_busy(input string name);
        checks++;
        if ({bus_valid_o, inst_valid_o, inst_err_o, mem_valid_o, mem_err_o} !== 5'b10000) begin
            failures++;
            $display("FAIL %s: got bv=%b iv=%b ie=%b mv=%b me=%b, expected bv=1 and no strobe",
                     name, bus_valid_o, inst_valid_o, inst_err_o, mem_valid_o, mem_err_o);
        end
    endtask

    task automatic raise_inst();
        inst_addr_i = $urandom;
        inst_req_i  = 1'b1;
    endtask

    task automatic raise_mem();
        mem_addr_i = $urandom;
        mem_data_i = $urandom;
        {mem_read_i, mem_write_i} = 2'($urandom_range(0, 3));
        mem_req_i = 1'b1;
    endtask

    task automatic raise_random();
        int unsigned sel;
        sel = $urandom_range(1, 3);
        if (sel[0] && !inst_req_i) raise_inst();
        if (sel[1] && !mem_req_i) raise_mem();
        if (!inst_req_i && !mem_req_i) raise_mem();
    endtask

    // One complete transaction. Requests are already driven.
    // w: cycles until bus_valid_o is due; lat < 0 means the bus never answers.
    task automatic run_round(input int w, input int lat, input logic [DW-1:0] rdata,
                             output bit got_inst);
        bit              exp_i;
        bit              mw;
        bit              tmo;
        logic [AW+2:0]   e_ctl;
        logic [DW-1:0]   e_data;
        logic [4:0]      e_strb;

        // Winner and streak follow the arbitration rules directly
        exp_i = !(mem_req_i && !(inst_req_i && streak_m == MAXB));
        mw    = mem_write_i && !mem_read_i;
        if (exp_i)           streak_m = 0;
        else if (inst_req_i) streak_m = (streak_m < MAXB) ? streak_m + 1 : MAXB;
        else                 streak_m = 0;

        for (int i = 1; i <= w; i++) begin
            step();
            if (i < w) check_quiet("pre_grant");
        end

        if (exp_i) e_ctl = {1'b1, 1'b1, 1'b0, inst_addr_i};
        else       e_ctl = {1'b1, !mw, mw, mem_addr_i};
        checks++;
        if ({bus_valid_o, bus_read_o, bus_write_o, bus_addr_o} !== e_ctl) begin
            failures++;
            $display("FAIL grant_%s: got valid/rd/wr/addr=%b%b%b/%h expected %b%b%b/%h",
                     exp_i ? "inst" : "data", bus_valid_o, bus_read_o, bus_write_o, bus_addr_o,
                     e_ctl[AW+2], e_ctl[AW+1], e_ctl[AW], e_ctl[AW-1:0]);
        end
        if (exp_i || mw) begin
            e_data = exp_i ? '0 : mem_data_i;
            checks++;
            if (bus_data_o !== e_data) begin
                failures++;
                $display("FAIL bus_data: got %h expected %h", bus_data_o, e_data);
            end
        end

        tmo = (lat < 0);
        if (!tmo) begin
            for (int c = 0; c < lat; c++) begin
                step();
                check_busy("wait_resp");
            end
            bus_data_i  = rdata;
            bus_valid_i = 1'b1;
            step();
        end else begin
            for (int c = 1; c < TO; c++) begin
                step();
                check_busy("wait_timeout");
            end
            step();
        end

        if (exp_i) held_inst = tmo ? '0 : rdata[IW-1:0];
        else       held_mem  = (tmo || mw) ? '0 : rdata;
        e_strb = {1'b0, exp_i, exp_i && tmo, !exp_i, !exp_i && tmo};
        checks++;
        if ({bus_valid_o, inst_valid_o, inst_err_o, mem_valid_o, mem_err_o} !== e_strb ||
            inst_data_o !== held_inst || mem_data_o !== held_mem) begin
            failures++;
            $display("FAIL response: got bv/iv/ie/mv/me=%b%b%b%b%b idata=%h mdata=%h expected %b idata=%h mdata=%h",
                     bus_valid_o, inst_valid_o, inst_err_o, mem_valid_o, mem_err_o,
                     inst_data_o, mem_data_o, e_strb, held_inst, held_mem);
        end
        got_inst = inst_valid_o;

        if (inst_valid_o) inst_req_i = 1'b0;
        if (mem_valid_o)  mem_req_i  = 1'b0;
        if (!inst_valid_o && !mem_valid_o) begin
            if (exp_i) inst_req_i = 1'b0;
            else       mem_req_i  = 1'b0;
        end
        // Late bus completion landing in the response cycle
        if ($urandom_range(0, 1) == 1) begin
            bus_data_i  = $urandom;
            bus_valid_i = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_all_zero("reset_state");
        step();
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_single_fetch();
        bit g;
        inst_addr_i = 32'h0000_0100;
        inst_req_i  = 1'b1;
        run_round(1, 2, 32'h0000_ABCD, g);
        checks++;
        if (inst_data_o !== 16'hABCD || inst_err_o !== 1'b0) begin
            failures++;
            $display("FAIL single_fetch: got data=%h err=%b expected data=abcd err=0", inst_data_o, inst_err_o);
        end
        step();
        check_quiet("single_fetch_one_pulse");
    endtask

    task automatic test_write();
        bit g;
        mem_addr_i  = 32'h0000_2000;
        mem_data_i  = 32'hDEAD_BEEF;
        mem_write_i = 1'b1;
        mem_read_i  = 1'b0;
        mem_req_i   = 1'b1;
        run_round(1, 1, 32'h1234_5678, g);
        checks++;
        if (mem_data_o !== 32'h0 || mem_err_o !== 1'b0) begin
            failures++;
            $display("FAIL write_ack: got data=%h err=%b expected data=0 err=0", mem_data_o, mem_err_o);
        end
        step();
        check_quiet("write_after");
    endtask

    task automatic test_timeout();
        bit g;
        mem_addr_i  = $urandom;
        mem_data_i  = $urandom;
        mem_read_i  = 1'b1;
        mem_write_i = 1'b0;
        mem_req_i   = 1'b1;
        run_round(1, -1, '0, g);
        checks++;
        if (mem_err_o !== 1'b1 || mem_data_o !== 32'h0) begin
            failures++;
            $display("FAIL timeout_err: got err=%b data=%h expected err=1 data=0", mem_err_o, mem_data_o);
        end
        step();
        check_quiet("timeout_idle");
        bus_data_i  = 32'hCAFE_F00D;
        bus_valid_i = 1'b1;
        step();
        check_quiet("late_ack_ignored");
        step();
        check_quiet("late_ack_ignored_2");
    endtask

    task automatic test_contention();
        bit g;
        bit exp_order [10];
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        raise_inst();
        raise_mem();
        for (int r = 0; r < 10; r++) begin
            run_round((r == 0) ? 1 : 2, int'($urandom_range(0, 3)), $urandom, g);
            checks++;
            if (g !== exp_order[r]) begin
                failures++;
                $display("FAIL contention_order[%0d]: got %s expected %s", r,
                         g ? "I" : "D", exp_order[r] ? "I" : "D");
            end
            if (!inst_req_i) raise_inst();
            if (!mem_req_i)  raise_mem();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_addr_i  = $urandom;
        mem_data_i  = $urandom;
        mem_read_i  = 1'b1;
        mem_write_i = 1'b0;
        mem_req_i   = 1'b1;
        step();
        check_busy("reset_mid_busy");
        reset     = 1'b1;
        mem_req_i = 1'b0;
        step();
        check_all_zero("reset_mid_abandon");
        reset       = 1'b0;
        streak_m    = 0;
        held_inst   = '0;
        held_mem    = '0;
        bus_data_i  = $urandom;
        bus_valid_i = 1'b1;
        step();
        check_all_zero("reset_mid_stray_ack");
        step();
        check_all_zero("reset_mid_stray_ack_2");
    endtask

    task automatic test_random();
        bit g;
        int w;
        int k;
        int lat;
        do_reset();
        raise_random();
        w = 1;
        for (int r = 0; r < 60; r++) begin
            lat = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 5));
            run_round(w, lat, $urandom, g);
            if (!inst_req_i && !mem_req_i && $urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(1, 3));
                for (int i = 0; i < k; i++) begin
                    step();
                    check_quiet("idle_gap");
                    if ($urandom_range(0, 1) == 1) begin
                        bus_data_i  = $urandom;
                        bus_valid_i = 1'b1;
                    end
                end
                raise_random();
                w = 1;
            end else begin
                raise_random();
                w = 2;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_write();
        test_timeout();
        test_contention();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
